// File: rtl/host_debug_bridge.sv
// host_debug_bridge: host byte-stream command engine for memory B ports, debug reads, core reset and continue.
// Optional build macro HOST_BRIDGE_TIMEOUT_EN drops a partial command after TIMEOUT_CYCLES idle clocks.
module host_debug_bridge #(
   parameter int WORD_SIZE      = 18,
   parameter int ADDR_SIZE      = 18,
   parameter int NUM_MEMS       = 2,
   parameter int READ_LATENCY   = 2,
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [ADDR_SIZE-1:0]          mem_addr,
   output logic [WORD_SIZE-1:0]          mem_wdata,
   output logic [NUM_MEMS-1:0]           mem_wren,
   input  logic [NUM_MEMS*WORD_SIZE-1:0] mem_rdata,
   output logic                          processor_reset,
   input  logic                          wait_for_continue,
   output logic                          wait_continue_execution,
   output logic                          debug_get_param,
   output logic [3:0]                    debug_reg_addr,
   input  logic [WORD_SIZE-1:0]          debug_data_out
);
   localparam int AB = (ADDR_SIZE + 7) / 8;
   localparam int WB = (WORD_SIZE + 7) / 8;
   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NACK = 8'h5A;

   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, DBG_WAIT, SEND_WORD, SEND_ACK} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cmd_q, cmd_d, resp_q, resp_d, cnt_q, cnt_d;
   logic [AB*8-1:0] addr_q, addr_d;
   logic [WB*8-1:0] wdata_q, wdata_d, word_q, word_d;
   logic            rx_ready_q, rx_ready_d, prst_q, prst_d, cont_q, cont_d, dbg_q, dbg_d;
   logic [3:0]      dreg_q, dreg_d;
   logic            take, expired;

   assign take                    = rx_valid & rx_ready_q;
   assign rx_ready                = rx_ready_q;
   assign mem_addr                = addr_q[ADDR_SIZE-1:0];
   assign mem_wdata               = wdata_q[WORD_SIZE-1:0];
   assign processor_reset         = prst_q;
   assign wait_continue_execution = cont_q;
   assign debug_get_param         = dbg_q;
   assign debug_reg_addr          = dreg_q;

`ifdef HOST_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_q;
   assign expired = (state_q == GET_ADDR || state_q == GET_DATA) && !take && to_q == TW'(TIMEOUT_CYCLES - 1);
   // idle counter, restarted by every accepted byte and held at zero outside byte collection
   always_ff @(posedge clock or posedge reset)
      if (reset) to_q <= '0;
      else to_q <= (take || !(state_q == GET_ADDR || state_q == GET_DATA)) ? '0 : to_q + 1'b1;
`else
   assign expired = 1'b0;
`endif

   // state and datapath registers; reset aborts any command in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         resp_q     <= '0;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         rx_ready_q <= 1'b0;
         prst_q     <= 1'b1;
         cont_q     <= 1'b0;
         dbg_q      <= 1'b0;
         dreg_q     <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         resp_q     <= resp_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         word_q     <= word_d;
         rx_ready_q <= rx_ready_d;
         prst_q     <= prst_d;
         cont_q     <= cont_d;
         dbg_q      <= dbg_d;
         dreg_q     <= dreg_d;
      end
   end

   // command decode, byte collection (LSB first, shifted in from the top) and response sequencing
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      resp_d  = resp_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      prst_d  = prst_q;
      dreg_d  = dreg_q;
      cont_d  = 1'b0;
      dbg_d   = 1'b0;
      case (state_q)
         IDLE: if (take) begin
            cmd_d   = rx_data;
            cnt_d   = '0;
            state_d = SEND_ACK;
            resp_d  = NACK;
            if ((rx_data[7:4] == 4'h1 || rx_data[7:4] == 4'h2) && 32'(rx_data[3:0]) < NUM_MEMS) state_d = GET_ADDR;
            else if (rx_data[7:1] == 7'h18) begin
               prst_d = ~rx_data[0];
               resp_d = ACK;
            end else if (rx_data[7:4] == 4'h4) begin
               dbg_d   = 1'b1;
               dreg_d  = rx_data[3:0];
               state_d = DBG_WAIT;
            end else if (rx_data == 8'h50 && wait_for_continue) begin
               cont_d = 1'b1;
               resp_d = ACK;
            end
         end
         GET_ADDR: if (take) begin
            addr_d = (AB*8)'({rx_data, addr_q} >> 8);
            cnt_d  = cnt_q == 8'(AB - 1) ? '0 : cnt_q + 8'd1;
            if (cnt_q == 8'(AB - 1)) state_d = cmd_q[7:4] == 4'h1 ? GET_DATA : READ_WAIT;
         end
         GET_DATA: if (take) begin
            wdata_d = (WB*8)'({rx_data, wdata_q} >> 8);
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'(WB - 1)) state_d = WRITE;
         end
         WRITE: begin
            state_d = SEND_ACK;
            resp_d  = ACK;
         end
         READ_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(READ_LATENCY)) begin
               for (int m = 0; m < NUM_MEMS; m++)
                  if (cmd_q[3:0] == 4'(m)) word_d = (WB*8)'(mem_rdata[m*WORD_SIZE +: WORD_SIZE]);
               cnt_d   = '0;
               state_d = SEND_WORD;
            end
         end
         DBG_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin
               word_d  = (WB*8)'(debug_data_out);
               cnt_d   = '0;
               state_d = SEND_WORD;
            end
         end
         SEND_WORD: if (tx_ready) begin
            word_d  = word_q >> 8;
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == 8'(WB - 1)) state_d = IDLE;
         end
         default: if (tx_ready) state_d = IDLE;
      endcase
      if (expired) state_d = IDLE;
   end

   // link handshakes and one-hot write strobe derived from the FSM state
   always_comb begin
      rx_ready_d = state_d == IDLE || state_d == GET_ADDR || state_d == GET_DATA;
      tx_valid   = state_q == SEND_WORD || state_q == SEND_ACK;
      tx_data    = state_q == SEND_ACK ? resp_q : state_q == SEND_WORD ? word_q[7:0] : 8'h00;
      mem_wren   = state_q == WRITE ? NUM_MEMS'(1) << cmd_q[3:0] : '0;
   end
endmodule
